// File: rtl/bcd_entry.sv
// Keypad BCD entry: collects up to three digits and commits them to the
// converter input A with a one-cycle start strobe St.
module bcd_entry (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key,
    input  logic        key_dn,
    input  logic        enter,
    input  logic        clear,
    output logic [11:0] A,
    output logic        St,
    output logic [1:0]  cnt,
    output logic        err
);

    typedef enum logic [1:0] {ENTRY, COMMIT, ERROR} state_t;

    state_t      state_q, state_d;
    logic        key_dn_q, enter_q;
    logic        press_q, cmt_q;
    logic [3:0]  key_q;
    logic [11:0] p_q, p_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [11:0] a_q, a_d;
    logic        st_q, st_d;
    logic        press_d, cmt_d;

    // Edges are registered into one-cycle pulses; clear kills a pulse born
    // in its own cycle so a simultaneous press/enter leaves no trace.
    assign press_d = key_dn & ~key_dn_q & ~clear;
    assign cmt_d   = enter  & ~enter_q  & ~clear;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        a_d     = a_q;
        st_d    = 1'b0;
        if (clear) begin
            p_d     = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ENTRY;
        end else begin
            case (state_q)
                COMMIT: begin
                    a_d     = p_q;
                    st_d    = 1'b1;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = ENTRY;
                end
                ERROR: ;
                default: begin
                    if (cmt_q) begin
                        state_d = COMMIT;
                    end else if (press_q) begin
                        if (key_q > 4'd9) begin
                            err_d   = 1'b1;
                            state_d = ERROR;
                        end else if (cnt_q != 2'd3) begin
                            p_d   = {p_q[7:0], key_q};
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ENTRY;
            key_dn_q <= 1'b0;
            enter_q  <= 1'b0;
            press_q  <= 1'b0;
            cmt_q    <= 1'b0;
            key_q    <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            a_q      <= '0;
            st_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_dn_q <= key_dn;
            enter_q  <= enter;
            press_q  <= press_d;
            cmt_q    <= cmt_d;
            key_q    <= key;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            a_q      <= a_d;
            st_q     <= st_d;
        end
    end

    assign A   = a_q;
    assign St  = st_q;
    assign cnt = cnt_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_entry.sv
// Bench for bcd_entry: directed scenarios plus random keypad traffic checked
// every cycle against a digit-list reference model.
module tb_bcd_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic        key_dn, enter, clear;
    logic [11:0] A;
    logic        St, err;
    logic [1:0]  cnt;

    int n_chk = 0;
    int n_pass = 0;

    bcd_entry dut (
        .clk(clk), .rst(rst), .key(key), .key_dn(key_dn), .enter(enter),
        .clear(clear), .A(A), .St(St), .cnt(cnt), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: accepted digits kept as a list of integers.
    int          m_q[$];
    bit          m_err, m_cm, m_pc, m_kp, m_ep, m_St;
    int          m_pk;
    logic [11:0] m_A;

    function automatic logic [11:0] digits_val();
        int v = 0;
        foreach (m_q[i]) v = v * 16 + m_q[i];
        return 12'(v);
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_err = 0; m_cm = 0; m_pc = 0; m_kp = 0; m_ep = 0; m_St = 0;
        m_pk = -1; m_A = '0;
    endtask

    task automatic m_step();
        bit npc;
        int npk;
        npc  = enter && !m_ep && !clear;
        npk  = (key_dn && !m_kp && !clear) ? int'(key) : -1;
        m_St = 0;
        if (clear) begin
            m_q.delete(); m_err = 0; m_cm = 0;
        end else if (m_cm) begin
            m_A = digits_val(); m_St = 1; m_q.delete(); m_cm = 0;
        end else if (!m_err) begin
            if (m_pc) m_cm = 1;
            else if (m_pk >= 0) begin
                if (m_pk > 9) m_err = 1;
                else if (m_q.size() < 3) m_q.push_back(m_pk);
            end
        end
        m_pc = npc; m_pk = npk; m_ep = enter; m_kp = key_dn;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp_v);
    endtask

    task automatic chk_all();
        chk("A", 32'(A), 32'(m_A));
        chk("St", 32'(St), 32'(m_St));
        chk("cnt", 32'(cnt), 32'(m_q.size()));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic cyc(input logic [3:0] k, input logic kd, input logic e, input logic c);
        key = k; key_dn = kd; enter = e; clear = c;
        @(posedge clk);
        m_step();
        #1 chk_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(key, key_dn, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [3:0] k);
        cyc(k, 1'b1, 1'b0, 1'b0);
        cyc(k, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_enter();
        cyc(4'd0, 1'b0, 1'b1, 1'b0);
        cyc(4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1 m_reset();
        chk_all();
        #1 rst = 1'b0;
    endtask

    // Counts St pulses over the next n cycles while idle.
    task automatic count_st(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            cyc(4'd0, 1'b0, 1'b0, 1'b0);
            if (St) pulses++;
        end
    endtask

    initial begin
        int pulses;
        rst = 1'b1; key = '0; key_dn = 0; enter = 0; clear = 0;
        m_reset();
        #2 chk_all();
        rst = 1'b0;

        // 1,2,3 then enter: St exactly two edges after enter is sampled
        press(4'd1); press(4'd2); press(4'd3);
        chk("cnt3", 32'(cnt), 32'd3);
        cyc(4'd0, 1'b0, 1'b1, 1'b0);
        chk("st_early", 32'(St), 32'd0);
        cyc(4'd0, 1'b0, 1'b0, 1'b0);
        chk("st_early2", 32'(St), 32'd0);
        cyc(4'd0, 1'b0, 1'b0, 1'b0);
        chk("A123", 32'(A), 32'h123);
        chk("st_on", 32'(St), 32'd1);
        idle(2);
        chk("cnt0", 32'(cnt), 32'd0);

        // 4 held for 20 cycles
        cyc(4'd4, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("cnt_held", 32'(cnt), 32'd1);
        cyc(4'd4, 1'b0, 1'b0, 1'b0);
        do_enter();
        count_st(4, pulses);
        chk("A004", 32'(A), 32'h004);
        chk("st_pulses", 32'(pulses), 32'd1);

        // 4th digit dropped
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        do_enter(); idle(3);
        chk("A987", 32'(A), 32'h987);

        // bad digit: ERROR ignores presses and enter until clear
        press(4'd5); press(4'hC);
        chk("err_set", 32'(err), 32'd1);
        press(4'd1); do_enter(); count_st(4, pulses);
        chk("err_noSt", 32'(pulses), 32'd0);
        chk("err_A", 32'(A), 32'h987);
        cyc(4'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("err_clr", 32'(err), 32'd0);

        // empty entry commits zero; clear beats enter+press
        do_enter(); idle(3);
        chk("A000", 32'(A), 32'h000);
        cyc(4'd5, 1'b1, 1'b1, 1'b1);
        cyc(4'd5, 1'b0, 1'b0, 1'b0);
        count_st(4, pulses);
        chk("clr_noSt", 32'(pulses), 32'd0);
        chk("clr_cnt", 32'(cnt), 32'd0);

        // reset mid-entry then a fresh entry
        press(4'd2); do_enter(); idle(3);
        press(4'd3); press(4'd4);
        pulse_rst();
        do_enter(); idle(3);
        press(4'd7); do_enter(); idle(3);
        chk("A007", 32'(A), 32'h007);

        // reset during COMMIT gives no strobe
        press(4'd6);
        cyc(4'd0, 1'b0, 1'b1, 1'b0);
        cyc(4'd0, 1'b0, 1'b1, 1'b0);
        pulse_rst();
        count_st(3, pulses);
        chk("rst_noSt", 32'(pulses), 32'd0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] k;
            k = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                            : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 199) == 0) pulse_rst();
            cyc(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 29) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_entry.md
BCD_ENTRY -- requirements
Module: bcd_entry

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 key  input  4  BCD digit from the keypad, sampled with key_dn.
REQ-005 key_dn  input  1  keypad key-down level; may be held for many cycles.
REQ-006 enter  input  1  commit request, edge-detected.
REQ-007 clear  input  1  abort/clear request, level-sensitive.
REQ-008 A  output  12  committed 3-digit BCD value {hundreds, tens, units}; it drives the converter input.
REQ-009 St  output  1  one-cycle start strobe to the converter, aligned with the new A.
REQ-010 cnt  output  2  number of digits accepted in the current entry (0-3).
REQ-011 err  output  1  sticky error flag for a rejected digit.

Function
REQ-012 Key press detection: a press SHALL be the rising edge of key_dn (registered key_dn_q=0, key_dn=1); holding key_dn SHALL produce exactly one press.
REQ-013 Enter detection: a commit SHALL be the rising edge of enter, using the same registered-edge scheme.
REQ-014 Digit storage: the pending digit register SHALL be 12 bits, P, and separate from A.
REQ-015 FSM states SHALL be ENTRY, COMMIT and ERROR; the reset state is ENTRY.
REQ-016 ENTRY, valid press with key<=9 and cnt<3: P <= {P[7:0], key}; cnt <= cnt+1.
REQ-017 ENTRY, press with key>9 (A-F): P and cnt SHALL be unchanged; err<=1; next state ERROR.
REQ-018 ENTRY, press with cnt==3 (overflow): the digit SHALL be discarded; P, cnt and err unchanged; state stays ENTRY.
REQ-019 ENTRY, commit edge: next state COMMIT, for any cnt including 0; fewer than 3 digits are right-justified with leading zeros.
REQ-020 COMMIT (lasts exactly one cycle): A<=P; St<=1 for that single cycle; P<=0; cnt<=0; next state ENTRY.
REQ-021 Latency: St and the new A SHALL be visible on the 2nd rising edge after the edge that samples enter high (1 cycle for edge detection, 1 for COMMIT).
REQ-022 A SHALL hold its value between commits and SHALL NOT change while digits are being entered.
REQ-023 ERROR: presses and commit edges SHALL be ignored; the block stays in ERROR until clear.
REQ-024 clear=1 in any state SHALL set P<=0, cnt<=0, err<=0 and next state ENTRY; A SHALL be unchanged; St<=0.
REQ-025 Priority for simultaneous events in the same cycle SHALL be clear > commit edge > key press.
REQ-026 A key press in the same cycle as a commit edge SHALL be dropped, not queued.
REQ-027 A key press during COMMIT SHALL be dropped.
REQ-028 Edge detectors SHALL keep sampling in every state, so a key or enter held across clear/COMMIT produces no new edge.
REQ-029 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-030 rst=1 SHALL asynchronously force A=12'h000, St=0, cnt=0, err=0, P=0, key_dn_q=0, enter_q=0 and state ENTRY.
REQ-031 Reset asserted mid-entry or during COMMIT SHALL abort with no St pulse.
REQ-032 After rst falls, the first press SHALL be accepted only on a fresh rising edge of key_dn.

Verification
REQ-033 Presses 1,2,3 then an enter edge -> cnt 1,2,3; two cycles after enter, A=12'h123 and St high for exactly 1 cycle; cnt=0.
REQ-034 Press 4, then key_dn held 20 cycles, then enter -> A=12'h004, one St pulse, cnt was 1 before commit.
REQ-035 Presses 9,8,7,6 then enter -> 4th digit dropped; A=12'h987.
REQ-036 Presses 5, then key=4'hC -> err=1; further presses and enter do not change A and give no St; clear -> err=0, cnt=0, state ENTRY.
REQ-037 Enter with cnt=0 -> A=12'h000 with one St pulse; clear, enter and a press in the same cycle -> clear only, no St, cnt=0.
REQ-038 rst pulsed between the 2nd digit and enter -> A=0, cnt=0, no St; a subsequent entry of 7 then enter -> A=12'h007.
